// File: rtl/tcdm_bank_responder.sv
// +----------------------------------------------------------------------------+
// | tcdm_bank_responder : TCDM target endpoint for one single-port SRAM bank,  |
// |                       with AMO / LR-SC read-modify-write support.          |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

package tcdm_bank_pkg;
  localparam int unsigned DataWidth        = 32;
  localparam int unsigned BeWidth          = DataWidth / 8;
  localparam int unsigned TileAddrWidth    = 10;
  localparam int unsigned TCDMAddrMemWidth = 8;

  typedef logic [TileAddrWidth-1:0] tile_addr_t;
  typedef logic [3:0]               meta_id_t;
  typedef logic [1:0]               core_id_t;
  typedef logic [2:0]               ini_addr_t;
  typedef logic [3:0]               amo_t;

  localparam amo_t c_amo_none = 4'h0;
  localparam amo_t c_amo_swap = 4'h1;
  localparam amo_t c_amo_add  = 4'h2;
  localparam amo_t c_amo_and  = 4'h3;
  localparam amo_t c_amo_or   = 4'h4;
  localparam amo_t c_amo_xor  = 4'h5;
  localparam amo_t c_amo_max  = 4'h6;
  localparam amo_t c_amo_maxu = 4'h7;
  localparam amo_t c_amo_min  = 4'h8;
  localparam amo_t c_amo_minu = 4'h9;
  localparam amo_t c_amo_lr   = 4'hA;
  localparam amo_t c_amo_sc   = 4'hB;

  typedef struct packed {
    amo_t                 amo;
    logic [DataWidth-1:0] data;
  } tcdm_payload_t;

  typedef struct packed {
    meta_id_t           meta_id;
    core_id_t           core_id;
    ini_addr_t          ini_addr;
    tile_addr_t         tgt_addr;
    logic               wen;
    logic [BeWidth-1:0] be;
    tcdm_payload_t      wdata;
  } tcdm_slave_req_t;

  typedef struct packed {
    meta_id_t      meta_id;
    core_id_t      core_id;
    ini_addr_t     ini_addr;
    tcdm_payload_t rdata;
  } tcdm_slave_resp_t;
endpackage

module tcdm_bank_responder
  import tcdm_bank_pkg::*;
#(
  parameter int unsigned NumOutstanding = 2
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        req_valid_i,
  output logic                        req_ready_o,
  input  tcdm_slave_req_t             req_i,
  output logic                        resp_valid_o,
  input  logic                        resp_ready_i,
  output tcdm_slave_resp_t            resp_o,
  output logic                        mem_req_o,
  output logic                        mem_we_o,
  output logic [TCDMAddrMemWidth-1:0] mem_addr_o,
  output logic [DataWidth-1:0]        mem_wdata_o,
  output logic [BeWidth-1:0]          mem_be_o,
  input  logic [DataWidth-1:0]        mem_rdata_i
);

  localparam int unsigned c_ptr_w    = (NumOutstanding > 1) ? $clog2(NumOutstanding) : 1;
  localparam int unsigned c_cnt_w    = $clog2(NumOutstanding + 1);
  localparam int unsigned c_last_idx = NumOutstanding - 1;
  localparam logic [c_ptr_w-1:0] c_last_ptr = c_last_idx[c_ptr_w-1:0];
  localparam logic [c_cnt_w:0]   c_num_out  = (c_cnt_w + 1)'(NumOutstanding);

  // Request accepted last cycle; its response is formed once the bank read data arrives.
  typedef struct packed {
    logic                        valid;
    logic                        use_rdata;
    logic                        amo_wb;
    amo_t                        amo;
    logic [DataWidth-1:0]        imm;
    logic [DataWidth-1:0]        wdata;
    logic [BeWidth-1:0]          be;
    logic [TCDMAddrMemWidth-1:0] row;
    meta_id_t                    meta_id;
    core_id_t                    core_id;
    ini_addr_t                   ini_addr;
  } pend_t;

  pend_t                       r_pend;
  pend_t                       w_pend_next;
  logic                        r_res_valid;
  ini_addr_t                   r_res_ini;
  core_id_t                    r_res_core;
  logic [TCDMAddrMemWidth-1:0] r_res_row;

  tcdm_slave_resp_t            r_fifo [NumOutstanding];
  logic [c_ptr_w-1:0]          r_rd_ptr;
  logic [c_ptr_w-1:0]          r_wr_ptr;
  logic [c_cnt_w-1:0]          r_count;

  logic [TCDMAddrMemWidth-1:0] w_row;
  amo_t                        w_amo;
  logic                        w_is_rmw;
  logic                        w_is_lr;
  logic                        w_is_sc;
  logic                        w_is_wr;
  logic                        w_sc_ok;
  logic                        w_accept;
  logic                        w_wb;
  logic                        w_fifo_empty;
  logic                        w_pop;
  logic                        w_store;
  logic                        w_deq;
  logic [c_cnt_w:0]            w_occ;
  tcdm_slave_resp_t            w_pend_resp;
  logic                        w_unused;

  function automatic logic [DataWidth-1:0] amo_op(input amo_t op,
                                                  input logic [DataWidth-1:0] a,
                                                  input logic [DataWidth-1:0] b);
    logic [DataWidth-1:0] res;
    res = a;
    case (op)
      c_amo_swap: res = b;
      c_amo_add:  res = a + b;
      c_amo_and:  res = a & b;
      c_amo_or:   res = a | b;
      c_amo_xor:  res = a ^ b;
      c_amo_max:  res = ($signed(a) > $signed(b)) ? a : b;
      c_amo_maxu: res = (a > b) ? a : b;
      c_amo_min:  res = ($signed(a) < $signed(b)) ? a : b;
      c_amo_minu: res = (a < b) ? a : b;
      default:    res = a;
    endcase
    return res;
  endfunction

  assign w_unused = ^req_i.tgt_addr[TileAddrWidth-TCDMAddrMemWidth-1:0];

  assign w_row    = req_i.tgt_addr[$bits(tile_addr_t)-1 -: TCDMAddrMemWidth];
  assign w_amo    = req_i.wdata.amo;
  assign w_is_rmw = (w_amo >= c_amo_swap) && (w_amo <= c_amo_minu);
  assign w_is_lr  = (w_amo == c_amo_lr);
  assign w_is_sc  = (w_amo == c_amo_sc);
  assign w_is_wr  = req_i.wen && (w_amo == c_amo_none);
  assign w_sc_ok  = w_is_sc && r_res_valid && (r_res_ini == req_i.ini_addr)
                    && (r_res_core == req_i.core_id) && (r_res_row == w_row);
  assign w_accept = req_valid_i && req_ready_o;
  assign w_wb     = r_pend.valid && r_pend.amo_wb;

  always_comb begin
    w_pend_resp               = '0;
    w_pend_resp.meta_id       = r_pend.meta_id;
    w_pend_resp.core_id       = r_pend.core_id;
    w_pend_resp.ini_addr      = r_pend.ini_addr;
    w_pend_resp.rdata.amo     = c_amo_none;
    w_pend_resp.rdata.data    = r_pend.use_rdata ? mem_rdata_i : r_pend.imm;

    w_fifo_empty = (r_count == '0);
    resp_valid_o = !w_fifo_empty || r_pend.valid;
    resp_o       = w_fifo_empty ? w_pend_resp : r_fifo[r_rd_ptr];
    w_pop        = resp_valid_o && resp_ready_i;
    // An entry popped straight through while the FIFO is empty never gets stored.
    w_store      = r_pend.valid && !(w_pop && w_fifo_empty);
    w_deq        = w_pop && !w_fifo_empty;

    w_occ = {1'b0, r_count} + (c_cnt_w + 1)'(r_pend.valid) - (c_cnt_w + 1)'(w_pop);
    req_ready_o = !rst_i && !w_wb && (w_occ < c_num_out);
  end

  always_comb begin
    w_pend_next           = '0;
    w_pend_next.valid     = w_accept;
    w_pend_next.use_rdata = !w_is_wr && !w_is_sc;
    w_pend_next.amo_wb    = w_is_rmw;
    w_pend_next.amo       = w_amo;
    w_pend_next.imm       = {{(DataWidth-1){1'b0}}, w_is_sc && !w_sc_ok};
    w_pend_next.wdata     = req_i.wdata.data;
    w_pend_next.be        = req_i.be;
    w_pend_next.row       = w_row;
    w_pend_next.meta_id   = req_i.meta_id;
    w_pend_next.core_id   = req_i.core_id;
    w_pend_next.ini_addr  = req_i.ini_addr;
  end

  always_comb begin
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    mem_be_o    = '0;
    if (w_wb) begin
      mem_req_o   = 1'b1;
      mem_we_o    = 1'b1;
      mem_addr_o  = r_pend.row;
      mem_wdata_o = amo_op(r_pend.amo, mem_rdata_i, r_pend.wdata);
      mem_be_o    = r_pend.be;
    end else if (w_accept) begin
      mem_req_o   = !(w_is_sc && !w_sc_ok);
      mem_we_o    = w_is_wr || w_sc_ok;
      mem_addr_o  = w_row;
      mem_wdata_o = req_i.wdata.data;
      mem_be_o    = req_i.be;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_pend      <= '0;
      r_res_valid <= 1'b0;
      r_res_ini   <= '0;
      r_res_core  <= '0;
      r_res_row   <= '0;
    end else begin
      r_pend <= w_pend_next;
      if (w_accept) begin
        if (w_is_lr) begin
          r_res_valid <= 1'b1;
          r_res_ini   <= req_i.ini_addr;
          r_res_core  <= req_i.core_id;
          r_res_row   <= w_row;
        end else if (w_is_sc) begin
          r_res_valid <= 1'b0;
        end else if ((w_is_wr || w_is_rmw) && (w_row == r_res_row)) begin
          r_res_valid <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_store) begin
        r_wr_ptr <= (r_wr_ptr == c_last_ptr) ? '0 : r_wr_ptr + c_ptr_w'(1);
      end
      if (w_deq) begin
        r_rd_ptr <= (r_rd_ptr == c_last_ptr) ? '0 : r_rd_ptr + c_ptr_w'(1);
      end
      case ({w_store, w_deq})
        2'b10:   r_count <= r_count + c_cnt_w'(1);
        2'b01:   r_count <= r_count - c_cnt_w'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_store) begin
      r_fifo[r_wr_ptr] <= w_pend_resp;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_tcdm_bank_responder.sv
// +----------------------------------------------------------------------------+
// | tb_tcdm_bank_responder : directed self-checking bench for the bank target. |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_tcdm_bank_responder;
  import tcdm_bank_pkg::*;

  logic                        clk_i = 1'b0;
  logic                        rst_i;
  logic                        req_valid_i;
  logic                        req_ready_o;
  tcdm_slave_req_t             req_i;
  logic                        resp_valid_o;
  logic                        resp_ready_i;
  tcdm_slave_resp_t            resp_o;
  logic                        mem_req_o;
  logic                        mem_we_o;
  logic [TCDMAddrMemWidth-1:0] mem_addr_o;
  logic [DataWidth-1:0]        mem_wdata_o;
  logic [BeWidth-1:0]          mem_be_o;
  logic [DataWidth-1:0]        mem_rdata_i;

  logic [31:0] r_bank [256];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] d;
  int          s;

  tcdm_bank_responder #(.NumOutstanding(2)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .req_i        (req_i),
    .resp_valid_o (resp_valid_o),
    .resp_ready_i (resp_ready_i),
    .resp_o       (resp_o),
    .mem_req_o    (mem_req_o),
    .mem_we_o     (mem_we_o),
    .mem_addr_o   (mem_addr_o),
    .mem_wdata_o  (mem_wdata_o),
    .mem_be_o     (mem_be_o),
    .mem_rdata_i  (mem_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  // Behavioural single-port bank: one-cycle read latency, byte-enabled writes.
  always @(posedge clk_i) begin
    if (mem_req_o) begin
      if (mem_we_o) begin
        for (int b = 0; b < 4; b++) begin
          if (mem_be_o[b]) r_bank[mem_addr_o][8*b +: 8] <= mem_wdata_o[8*b +: 8];
        end
      end else begin
        mem_rdata_i <= r_bank[mem_addr_o];
      end
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input logic wen, input logic [3:0] amo, input logic [7:0] row,
                         input logic [31:0] data, input logic [1:0] core,
                         input logic [2:0] ini, input logic [3:0] meta);
    req_i            = '0;
    req_i.wen        = wen;
    req_i.wdata.amo  = amo;
    req_i.tgt_addr   = {row, 2'b00};
    req_i.wdata.data = data;
    req_i.be         = 4'hF;
    req_i.core_id    = core;
    req_i.ini_addr   = ini;
    req_i.meta_id    = meta;
  endtask

  // One request/response pair with resp_ready held high; returns data and stall cycles.
  task automatic xact(input string tag, input logic wen, input logic [3:0] amo,
                      input logic [7:0] row, input logic [31:0] data, input logic [1:0] core,
                      input logic [2:0] ini, input logic [3:0] meta,
                      output logic [31:0] rdata, output int stall);
    set_req(wen, amo, row, data, core, ini, meta);
    req_valid_i = 1'b1;
    stall = 0;
    #1;
    while (!req_ready_o && stall < 20) begin
      stall++;
      @(negedge clk_i);
      #1;
    end
    if (!req_ready_o) check_eq({tag, "_accept"}, {63'd0, req_ready_o}, 64'd1);
    @(posedge clk_i);
    #1 req_valid_i = 1'b0;
    @(negedge clk_i);
    check_eq({tag, "_rvalid"}, {63'd0, resp_valid_o}, 64'd1);
    check_eq({tag, "_hdr"}, {51'd0, resp_o.meta_id, resp_o.core_id, resp_o.ini_addr, resp_o.rdata.amo},
             {51'd0, meta, core, ini, 4'h0});
    rdata = resp_o.rdata.data;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 256; i++) r_bank[i] = '0;
    mem_rdata_i  = '0;
    rst_i        = 1'b1;
    req_valid_i  = 1'b0;
    resp_ready_i = 1'b1;
    req_i        = '0;
    repeat (2) @(negedge clk_i);
    check_eq("rst_ready", {63'd0, req_ready_o}, 64'd0);
    check_eq("rst_rvalid", {63'd0, resp_valid_o}, 64'd0);
    check_eq("rst_memreq", {63'd0, mem_req_o}, 64'd0);
    check_eq("rst_memwe", {63'd0, mem_we_o}, 64'd0);
    rst_i = 1'b0;
    #1 check_eq("post_rst_ready", {63'd0, req_ready_o}, 64'd1);

    // Write then back-to-back read of the same row.
    xact("wr5", 1, 4'h0, 5, 32'hDEADBEEF, 1, 2, 3, d, s);
    check_eq("wr5_data", {32'd0, d}, 64'h0);
    xact("rd5", 0, 4'h0, 5, 32'h0, 2, 5, 4, d, s);
    check_eq("rd5_data", {32'd0, d}, 64'hDEADBEEF);
    check_eq("rd5_stall", s, 0);

    // ADD wraps into the sign bit; write-back cycle blocks one acceptance.
    xact("wr3", 1, 4'h0, 3, 32'h7FFFFFFF, 0, 0, 1, d, s);
    xact("add3", 0, 4'h2, 3, 32'h1, 0, 1, 2, d, s);
    check_eq("add3_old", {32'd0, d}, 64'h7FFFFFFF);
    check_eq("add3_stall", s, 0);
    xact("rd3", 0, 4'h0, 3, 32'h0, 0, 1, 3, d, s);
    check_eq("rd3_data", {32'd0, d}, 64'h80000000);
    check_eq("rd3_stall", s, 1);

    // Signed versus unsigned compares.
    xact("wr2a", 1, 4'h0, 2, 32'hFFFFFFFF, 0, 0, 4, d, s);
    xact("max2", 0, 4'h6, 2, 32'h1, 0, 0, 5, d, s);
    check_eq("max2_old", {32'd0, d}, 64'hFFFFFFFF);
    xact("rd2a", 0, 4'h0, 2, 32'h0, 0, 0, 6, d, s);
    check_eq("rd2a_data", {32'd0, d}, 64'h1);
    xact("wr2b", 1, 4'h0, 2, 32'hFFFFFFFF, 0, 0, 7, d, s);
    xact("maxu2", 0, 4'h7, 2, 32'h1, 0, 0, 8, d, s);
    xact("rd2b", 0, 4'h0, 2, 32'h0, 0, 0, 9, d, s);
    check_eq("rd2b_data", {32'd0, d}, 64'hFFFFFFFF);
    xact("min2", 0, 4'h8, 2, 32'h1, 0, 0, 10, d, s);
    xact("rd2c", 0, 4'h0, 2, 32'h0, 0, 0, 11, d, s);
    check_eq("rd2c_data", {32'd0, d}, 64'hFFFFFFFF);
    xact("minu2", 0, 4'h9, 2, 32'h1, 0, 0, 12, d, s);
    xact("rd2d", 0, 4'h0, 2, 32'h0, 0, 0, 13, d, s);
    check_eq("rd2d_data", {32'd0, d}, 64'h1);

    // LR/SC success, then a repeated SC fails.
    xact("lr7", 0, 4'hA, 7, 32'h0, 1, 2, 1, d, s);
    check_eq("lr7_data", {32'd0, d}, 64'h0);
    xact("sc7", 0, 4'hB, 7, 32'h55, 1, 2, 2, d, s);
    check_eq("sc7_ok", {32'd0, d}, 64'h0);
    xact("rd7a", 0, 4'h0, 7, 32'h0, 1, 2, 3, d, s);
    check_eq("rd7a_data", {32'd0, d}, 64'h55);
    xact("sc7b", 0, 4'hB, 7, 32'h66, 1, 2, 4, d, s);
    check_eq("sc7b_fail", {32'd0, d}, 64'h1);
    xact("rd7b", 0, 4'h0, 7, 32'h0, 1, 2, 5, d, s);
    check_eq("rd7b_data", {32'd0, d}, 64'h55);

    // An intervening write from another core kills the reservation.
    xact("lr7c", 0, 4'hA, 7, 32'h0, 1, 2, 6, d, s);
    check_eq("lr7c_data", {32'd0, d}, 64'h55);
    xact("wr7", 1, 4'h0, 7, 32'hAA, 0, 0, 7, d, s);
    xact("sc7c", 0, 4'hB, 7, 32'h77, 1, 2, 8, d, s);
    check_eq("sc7c_fail", {32'd0, d}, 64'h1);
    xact("rd7c", 0, 4'h0, 7, 32'h0, 1, 2, 9, d, s);
    check_eq("rd7c_data", {32'd0, d}, 64'hAA);

    // SC from a different core than the LR fails.
    xact("lr7d", 0, 4'hA, 7, 32'h0, 1, 2, 10, d, s);
    xact("sc7d", 0, 4'hB, 7, 32'h88, 2, 2, 11, d, s);
    check_eq("sc7d_fail", {32'd0, d}, 64'h1);
    xact("rd7d", 0, 4'h0, 7, 32'h0, 1, 2, 12, d, s);
    check_eq("rd7d_data", {32'd0, d}, 64'hAA);

    // Full response buffer with back-pressure.
    xact("wr10", 1, 4'h0, 10, 32'h1000000A, 0, 0, 0, d, s);
    xact("wr11", 1, 4'h0, 11, 32'h1000000B, 0, 0, 0, d, s);
    xact("wr12", 1, 4'h0, 12, 32'h1000000C, 0, 0, 0, d, s);
    @(posedge clk_i);
    #1 resp_ready_i = 1'b0;
    set_req(0, 4'h0, 10, 32'h0, 0, 0, 1);
    req_valid_i = 1'b1;
    @(posedge clk_i);
    #1 set_req(0, 4'h0, 11, 32'h0, 0, 0, 2);
    @(posedge clk_i);
    #1 set_req(0, 4'h0, 12, 32'h0, 0, 0, 3);
    @(negedge clk_i);
    check_eq("full_ready", {63'd0, req_ready_o}, 64'd0);
    check_eq("full_head", {32'd0, resp_o.rdata.data}, 64'h1000000A);
    check_eq("full_meta", {60'd0, resp_o.meta_id}, 64'd1);
    @(negedge clk_i);
    check_eq("stall_ready", {63'd0, req_ready_o}, 64'd0);
    check_eq("stall_hold", {32'd0, resp_o.rdata.data}, 64'h1000000A);
    resp_ready_i = 1'b1;
    #1 check_eq("credit_ready", {63'd0, req_ready_o}, 64'd1);
    @(posedge clk_i);
    #1 req_valid_i = 1'b0;
    @(negedge clk_i);
    check_eq("ord1", {28'd0, resp_o.meta_id, resp_o.rdata.data}, {28'd0, 4'd2, 32'h1000000B});
    @(negedge clk_i);
    check_eq("ord2", {28'd0, resp_o.meta_id, resp_o.rdata.data}, {28'd0, 4'd3, 32'h1000000C});
    @(negedge clk_i);
    check_eq("drained", {63'd0, resp_valid_o}, 64'd0);

    // Reset in the AMO write-back cycle with a buffered response.
    xact("wr20", 1, 4'h0, 20, 32'h1234, 0, 0, 0, d, s);
    @(posedge clk_i);
    #1 resp_ready_i = 1'b0;
    set_req(0, 4'h1, 20, 32'h9999, 0, 0, 7);
    req_valid_i = 1'b1;
    #1 check_eq("swap_ready", {63'd0, req_ready_o}, 64'd1);
    @(posedge clk_i);
    #1 req_valid_i = 1'b0;
    @(negedge clk_i);
    check_eq("swap_rvalid", {63'd0, resp_valid_o}, 64'd1);
    check_eq("swap_wb_we", {63'd0, mem_we_o}, 64'd1);
    check_eq("swap_old", {32'd0, resp_o.rdata.data}, 64'h1234);
    rst_i = 1'b1;
    #1;
    check_eq("midrst_rvalid", {63'd0, resp_valid_o}, 64'd0);
    check_eq("midrst_memreq", {63'd0, mem_req_o}, 64'd0);
    check_eq("midrst_ready", {63'd0, req_ready_o}, 64'd0);
    @(negedge clk_i);
    rst_i = 1'b0;
    resp_ready_i = 1'b1;
    #1 check_eq("postrst_rvalid", {63'd0, resp_valid_o}, 64'd0);
    xact("rd20", 0, 4'h0, 20, 32'h0, 0, 0, 1, d, s);
    check_eq("rd20_data", {32'd0, d}, 64'h1234);

    repeat (2) @(negedge clk_i);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
